// File: rtl/uart_rx_packer.sv
// 8N1 UART receiver (16x oversampling) packing N_BIT/8 bytes LSB-first into one word; valid rises 1 clk after final stop sample.
// Holds a single word: a completed word while one is pending (and not acked that cycle) is dropped with an overrun pulse.
`timescale 1ns/1ps
module uart_rx_packer #(
  parameter int BAUDRATE   = 115200,
  parameter int CLK_PERIOD = 100000000,
  parameter int N_BIT      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [N_BIT-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ack,
  output logic             frame_err,
  output logic             overrun
);
  localparam int DIV = CLK_PERIOD / (BAUDRATE * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NB  = N_BIT / 8;
  localparam int IW  = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DW-1:0]    div_q;
  logic [3:0]       os_q, os_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_BIT-1:0] word_q, word_d;
  logic [N_BIT-1:0] dout_q, dout_d;
  logic             dvld_q, dvld_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             tick;
  logic             done;

  assign tick = (div_q == DW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      div_q     <= '0;
      state_q   <= IDLE;
      os_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      dout_q    <= '0;
      dvld_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      div_q     <= tick ? '0 : div_q + DW'(1);
      state_q   <= state_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      dout_q    <= dout_d;
      dvld_q    <= dvld_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    word_d  = word_q;
    dout_d  = dout_q;
    dvld_d  = dvld_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    done    = 1'b0;

    if (dvld_q && data_ack) dvld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = START;
          os_d    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (os_q == 4'd7) begin
            if (rx_sync_q) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              os_d    = '0;
              bit_d   = '0;
            end
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          os_d = os_q + 4'd1;
          if (os_q == 4'd15) begin
            shift_d = {rx_sync_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          os_d = os_q + 4'd1;
          if (os_q == 4'd15) begin
            if (rx_sync_q) begin
              state_d = IDLE;
              for (int k = 0; k < NB; k++) begin
                if (idx_q == IW'(k)) word_d[8*k +: 8] = shift_q;
              end
              if (idx_q == IW'(NB - 1)) begin
                idx_d = '0;
                done  = 1'b1;
              end else begin
                idx_d = idx_q + IW'(1);
              end
            end else begin
              // Bad stop bit poisons the whole word being assembled.
              ferr_d  = 1'b1;
              idx_d   = '0;
              state_d = BRK;
            end
          end
        end
      end
      BRK: begin
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      if (!dvld_q || data_ack) begin
        dout_d = word_d;
        dvld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dvld_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
endmodule
